serial_comp: RTL
================

SERIAL_COMP -- requirements
Module: serial_comp

Interface
REQ-001 Parameter WORDSIZE, default 16: width of compared words, SHALL be >= 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 a  input  WORDSIZE  first operand, unsigned, sampled on input handshake.
REQ-005 b  input  WORDSIZE  second operand, unsigned, sampled on input handshake.
REQ-006 in_valid  input  1  operands present.
REQ-007 in_ready  output  1  block can accept operands.
REQ-008 out_valid  output  1  lt/gt/eq hold a valid result.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 lt  output  1  a < b.
REQ-011 gt  output  1  a > b.
REQ-012 eq  output  1  a == b.

Function
REQ-013 The block SHALL be an FSM with states IDLE, RUN and DONE; it SHALL compare bit-serially, MSB first, one bit per cycle.
REQ-014 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready, a/b SHALL load into shift registers, bit counter cleared, gt_acc/lt_acc cleared, next state RUN.
REQ-015 RUN: each cycle the current MSBs SHALL be compared; if neither accumulator is set, a_bit>b_bit sets gt_acc and a_bit<b_bit sets lt_acc; both registers shift left by one; counter increments.
REQ-016 Once gt_acc or lt_acc is set it SHALL NOT change until the next load (first differing bit decides).
REQ-017 RUN SHALL last exactly WORDSIZE cycles with no early exit; the transition to DONE occurs on the edge where counter == WORDSIZE-1.
REQ-018 Latency: out_valid SHALL rise on the WORDSIZE-th rising edge after the accepting edge.
REQ-019 DONE: out_valid=1, lt=lt_acc, gt=gt_acc, eq=!(lt_acc|gt_acc); exactly one of lt/gt/eq SHALL be 1.
REQ-020 DONE SHALL hold outputs stable while out_ready=0; on out_valid&&out_ready the next state SHALL be IDLE.
REQ-021 Outside DONE, lt, gt, eq and out_valid SHALL be 0.
REQ-022 in_ready SHALL be 0 in RUN and DONE; in_valid there SHALL be ignored and a/b changes SHALL NOT affect the result.
REQ-023 Minimum spacing between accepted inputs SHALL be WORDSIZE+2 cycles (accept, WORDSIZE RUN cycles, one DONE cycle with out_ready=1, return to IDLE).
REQ-024 The counter SHALL be $clog2(WORDSIZE) bits and SHALL never wrap in RUN.

Reset
REQ-025 Asserting rst SHALL immediately force IDLE, clear shift registers, counter and accumulators, and drive out_valid=lt=gt=eq=0, in_ready=1 after release.
REQ-026 Reset asserted mid-RUN or mid-DONE SHALL discard the operation; no result SHALL be produced for it.

Structure
REQ-027 A shared package SHALL hold the state enum (IDLE/RUN/DONE) and the default WORDSIZE constant.
REQ-028 One sub-module comp_bit_cell SHALL implement the one-bit decision step (inputs a_bit, b_bit, gt_in, lt_in; outputs gt_out, lt_out); the FSM, counter and shift registers stay in serial_comp.

Verification
REQ-029 a=16'h8000, b=16'h7FFF accepted -> out_valid after 16 edges, gt=1, lt=0, eq=0.
REQ-030 a=b=16'hA5A5 -> eq=1, lt=gt=0 after 16 edges.
REQ-031 a=16'h0001, b=16'h0002 (decision on next-to-last bit) -> lt=1; in_valid held high during RUN with changing a/b -> result unchanged.
REQ-032 out_ready held 0 for 5 cycles in DONE -> out_valid and lt/gt/eq stable, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-033 rst pulsed at RUN cycle 7 -> outputs 0, in_ready=1 after release, no out_valid; a new operation then completes correctly.
REQ-034 Back-to-back operations with out_ready tied 1 and in_valid tied 1 -> accepts every 18 cycles, results match reference comparison.

Source files
------------

// File: rtl/serial_comp_pkg.sv
// Shared definitions for the bit-serial magnitude comparator.
// Holds the controller state encoding and the default operand width so the
// top level, its helper cell and any bench agree on the same values.
package serial_comp_pkg;

    // Default width of the compared words.
    localparam int DEFAULT_WORDSIZE = 16;

    // Controller states: waiting for operands, shifting bits, holding result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_comp_bit_cell.sv
// One-bit decision step of the serial comparator.
// Ports:
//   a_bit, b_bit   current MSBs of the two operands
//   gt_in, lt_in   decision accumulated so far
//   gt_out, lt_out updated decision
// The first differing bit decides the result. After that the accumulators
// are frozen, so later bits can never change the outcome.
module comp_bit_cell (
    input  logic a_bit,
    input  logic b_bit,
    input  logic gt_in,
    input  logic lt_in,
    output logic gt_out,
    output logic lt_out
);

    logic undecided;

    // No decision yet only while both accumulators are still clear.
    assign undecided = !gt_in && !lt_in;
    assign gt_out    = gt_in | (undecided &  a_bit & ~b_bit);
    assign lt_out    = lt_in | (undecided & ~a_bit &  b_bit);

endmodule

// File: rtl/serial_comp.sv
// Bit-serial unsigned comparator, MSB first, one bit per clock.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   a, b                operands, captured when in_valid && in_ready
//   in_valid, in_ready  input handshake (ready only while IDLE)
//   out_valid, out_ready result handshake (valid only while DONE)
//   lt, gt, eq          comparison result, one-hot while out_valid
// An operation always spends exactly WORDSIZE cycles in RUN. The result
// therefore appears WORDSIZE edges after the accepting edge, regardless of
// where the first differing bit lies.
module serial_comp
    import serial_comp_pkg::*;
#(
    parameter int WORDSIZE = DEFAULT_WORDSIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WORDSIZE-1:0] a,
    input  logic [WORDSIZE-1:0] b,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                lt,
    output logic                gt,
    output logic                eq
);

    localparam int CW = $clog2(WORDSIZE);
    localparam logic [CW-1:0] LAST_BIT = CW'(WORDSIZE - 1);

    state_t              state_q, state_d;
    logic [WORDSIZE-1:0] aShift_q, aShift_d;
    logic [WORDSIZE-1:0] bShift_q, bShift_d;
    logic [CW-1:0]       count_q, count_d;
    logic                gtAcc_q, gtAcc_d;
    logic                ltAcc_q, ltAcc_d;
    logic                cellGt, cellLt;

    // The decision step works on the MSBs currently sitting at the top of
    // the shift registers.
    comp_bit_cell u_cell (
        .a_bit  (aShift_q[WORDSIZE-1]),
        .b_bit  (bShift_q[WORDSIZE-1]),
        .gt_in  (gtAcc_q),
        .lt_in  (ltAcc_q),
        .gt_out (cellGt),
        .lt_out (cellLt)
    );

    // State and datapath registers. Reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            aShift_q <= '0;
            bShift_q <= '0;
            count_q  <= '0;
            gtAcc_q  <= 1'b0;
            ltAcc_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            aShift_q <= aShift_d;
            bShift_q <= bShift_d;
            count_q  <= count_d;
            gtAcc_q  <= gtAcc_d;
            ltAcc_q  <= ltAcc_d;
        end
    end

    // Next-state logic. Operands are loaded only in IDLE, so input activity
    // during RUN or DONE cannot disturb the operation in progress. On the
    // last RUN cycle the counter holds instead of incrementing, so it never
    // wraps.
    always_comb begin
        state_d  = state_q;
        aShift_d = aShift_q;
        bShift_d = bShift_q;
        count_d  = count_q;
        gtAcc_d  = gtAcc_q;
        ltAcc_d  = ltAcc_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    aShift_d = a;
                    bShift_d = b;
                    count_d  = '0;
                    gtAcc_d  = 1'b0;
                    ltAcc_d  = 1'b0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                gtAcc_d  = cellGt;
                ltAcc_d  = cellLt;
                aShift_d = {aShift_q[WORDSIZE-2:0], 1'b0};
                bShift_d = {bShift_q[WORDSIZE-2:0], 1'b0};
                if (count_q == LAST_BIT) begin
                    state_d = DONE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshakes and the result are decoded purely from the state, so they
    // are all zero outside DONE and stay stable while the consumer stalls.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign lt        = out_valid & ltAcc_q;
    assign gt        = out_valid & gtAcc_q;
    assign eq        = out_valid & ~(ltAcc_q | gtAcc_q);

endmodule
